// File: rtl/kalman_pkg.sv
// Shared types for the Kalman track scheduler: FSM states, per-track state record,
// and the coast-prediction helper (saturating position + signed velocity).
// Pure declarations; no logic of its own.
package kalman_pkg;

    localparam int POS_W = 16;
    localparam int VEL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } sched_state_t;

    typedef struct packed {
        logic        [POS_W-1:0] x;
        logic        [POS_W-1:0] y;
        logic signed [VEL_W-1:0] vx;
        logic signed [VEL_W-1:0] vy;
    } track_state_t;

    // Predicted position p + v, clamped to the unsigned pixel range.
    function automatic logic [POS_W-1:0] coast_pos(input logic [POS_W-1:0] p,
                                                   input logic signed [VEL_W-1:0] v);
        logic [POS_W+1:0] s;
        s = {2'b00, p} + {{(POS_W+2-VEL_W){v[VEL_W-1]}}, v};
        if (s[POS_W+1])
            coast_pos = '0;
        else if (s[POS_W])
            coast_pos = '1;
        else
            coast_pos = s[POS_W-1:0];
    endfunction

endpackage

// File: rtl/kalman_track_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when a grant is taken.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   s;
    logic [IW-1:0] j;

    // Scan from the far end back to ptr so the candidate closest to ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        s   = '0;
        j   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (IW+1)'(i);
            if (s >= (IW+1)'(N))
                s = s - (IW+1)'(N);
            j = s[IW-1:0];
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kalman_track_sched.sv
// Shares one stateless Kalman update unit among N_TRACKS sources; owns the track table and ages tracks.
// Latency: grant-to-ack CALC_LAT+2 cycles, one IDLE cycle between operations. Optional: KALMAN_SCHED_COAST_EN.
// Backpressure: sources hold i_Meas_Valid until o_Meas_Ack; frame ticks seen while busy are deferred to IDLE.
module kalman_track_sched
    import kalman_pkg::*;
#(
    parameter  int N_TRACKS = 4,
    parameter  int CALC_LAT = 2,
    parameter  int TIMEOUT  = 8,
    localparam int IW       = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Frame_Tick,
    input  logic [N_TRACKS-1:0]      i_Meas_Valid,
    input  logic [N_TRACKS*16-1:0]   i_Meas_X,
    input  logic [N_TRACKS*16-1:0]   i_Meas_Y,
    output logic [N_TRACKS-1:0]      o_Meas_Ack,
    output logic                     o_Kf_Start,
    output logic                     o_Kf_Init,
    output logic [15:0]              o_Kf_Z_X,
    output logic [15:0]              o_Kf_Z_Y,
    output logic [15:0]              o_Kf_Prev_X,
    output logic [15:0]              o_Kf_Prev_Y,
    output logic signed [15:0]       o_Kf_Prev_VX,
    output logic signed [15:0]       o_Kf_Prev_VY,
    input  logic [15:0]              i_Kf_X,
    input  logic [15:0]              i_Kf_Y,
    input  logic signed [15:0]       i_Kf_VX,
    input  logic signed [15:0]       i_Kf_VY,
    output logic                     o_Upd_Valid,
    output logic [IW-1:0]            o_Upd_Track,
    output logic [15:0]              o_Upd_X,
    output logic [15:0]              o_Upd_Y,
    output logic signed [15:0]       o_Upd_VX,
    output logic signed [15:0]       o_Upd_VY,
    output logic [N_TRACKS-1:0]      o_Track_Active
);

    sched_state_t          st_q, st_d;
    logic [IW-1:0]         ptr_q, ptr_d, gidx_q, gidx_d, upd_trk_q, upd_trk_d;
    track_state_t          tbl_q [N_TRACKS];
    track_state_t          tbl_d [N_TRACKS];
    logic [3:0]            miss_q [N_TRACKS];
    logic [3:0]            miss_d [N_TRACKS];
    logic [N_TRACKS-1:0]   act_q, act_d, wr_q, wr_d, ack_q, ack_d;
    logic                  tick_pend_q, tick_pend_d, start_q, start_d, init_q, init_d;
    logic                  upd_vld_q, upd_vld_d, meas_op;
    logic [15:0]           zx_q, zx_d, zy_q, zy_d;
    track_state_t          prev_q, prev_d, upd_q, upd_d, kf_res;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [N_TRACKS-1:0]   arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;

    assign kf_res = {i_Kf_X, i_Kf_Y, i_Kf_VX, i_Kf_VY};

    // A request whose ack is on the wire this cycle is already served.
    rr_arbiter #(.N(N_TRACKS)) u_arb (
        .req (i_Meas_Valid & ~ack_q),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

`ifdef KALMAN_SCHED_COAST_EN
    logic [N_TRACKS-1:0] coast_q, coast_d, carb_gnt;
    logic [IW-1:0]       carb_idx;
    logic                carb_any, is_coast_q, is_coast_d;

    rr_arbiter #(.N(N_TRACKS)) u_coast_arb (
        .req (coast_q & act_q),
        .ptr (ptr_q),
        .gnt (carb_gnt),
        .idx (carb_idx),
        .any (carb_any)
    );
    assign meas_op = !is_coast_q;
`else
    assign meas_op = 1'b1;
`endif

    // Next-state: arbitration, operation sequencing, table write-back and frame aging.
    always_comb begin
        st_d        = st_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        upd_trk_d   = upd_trk_q;
        tbl_d       = tbl_q;
        miss_d      = miss_q;
        act_d       = act_q;
        wr_d        = wr_q;
        ack_d       = '0;
        tick_pend_d = tick_pend_q;
        start_d     = 1'b0;
        init_d      = 1'b0;
        upd_vld_d   = 1'b0;
        zx_d        = zx_q;
        zy_d        = zy_q;
        prev_d      = prev_q;
        upd_d       = upd_q;
        wcnt_d      = wcnt_q;
`ifdef KALMAN_SCHED_COAST_EN
        coast_d     = coast_q;
        is_coast_d  = is_coast_q;
`endif
        if (i_Frame_Tick && st_q != ST_IDLE)
            tick_pend_d = 1'b1;

        case (st_q)
            ST_IDLE: begin
                // Aging takes the whole IDLE cycle so a grant never races a drop.
                if (i_Frame_Tick || tick_pend_q) begin
                    tick_pend_d = 1'b0;
                    for (int k = 0; k < N_TRACKS; k++) begin
                        if (act_q[k] && !wr_q[k]) begin
                            miss_d[k] = (miss_q[k] == 4'hF) ? 4'hF : miss_q[k] + 4'd1;
                            if (miss_d[k] == 4'(TIMEOUT))
                                act_d[k] = 1'b0;
`ifdef KALMAN_SCHED_COAST_EN
                            else
                                coast_d[k] = 1'b1;
`endif
                        end
                    end
                    wr_d = '0;
                end else if (arb_any) begin
                    gidx_d  = arb_idx;
                    zx_d    = i_Meas_X[arb_idx*16 +: 16];
                    zy_d    = i_Meas_Y[arb_idx*16 +: 16];
                    prev_d  = tbl_q[arb_idx];
                    init_d  = ~|(arb_gnt & act_q);
                    start_d = |(arb_gnt & act_q);
                    st_d    = ST_ISSUE;
`ifdef KALMAN_SCHED_COAST_EN
                    is_coast_d = 1'b0;
                end else if (carb_any) begin
                    gidx_d     = carb_idx;
                    zx_d       = coast_pos(tbl_q[carb_idx].x, tbl_q[carb_idx].vx);
                    zy_d       = coast_pos(tbl_q[carb_idx].y, tbl_q[carb_idx].vy);
                    prev_d     = tbl_q[carb_idx];
                    start_d    = |(carb_gnt & act_q);
                    coast_d[carb_idx] = 1'b0;
                    is_coast_d = 1'b1;
                    st_d       = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                wcnt_d = '0;
                st_d   = (CALC_LAT == 1) ? ST_WRITE : ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == 8'(CALC_LAT - 2))
                    st_d = ST_WRITE;
                else
                    wcnt_d = wcnt_q + 8'd1;
            end
            ST_WRITE: begin
                tbl_d[gidx_q] = kf_res;
                upd_d         = kf_res;
                upd_trk_d     = gidx_q;
                upd_vld_d     = 1'b1;
                st_d          = ST_IDLE;
                if (meas_op) begin
                    ack_d[gidx_q]  = 1'b1;
                    act_d[gidx_q]  = 1'b1;
                    wr_d[gidx_q]   = 1'b1;
                    miss_d[gidx_q] = '0;
                    ptr_d = (gidx_q == IW'(N_TRACKS - 1)) ? '0 : gidx_q + IW'(1);
`ifdef KALMAN_SCHED_COAST_EN
                    coast_d[gidx_q] = 1'b0;
`endif
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // FSM and all registered state/outputs; reset clears everything at once.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            st_q        <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            upd_trk_q   <= '0;
            for (int k = 0; k < N_TRACKS; k++) begin
                tbl_q[k]  <= '0;
                miss_q[k] <= '0;
            end
            act_q       <= '0;
            wr_q        <= '0;
            ack_q       <= '0;
            tick_pend_q <= 1'b0;
            start_q     <= 1'b0;
            init_q      <= 1'b0;
            upd_vld_q   <= 1'b0;
            zx_q        <= '0;
            zy_q        <= '0;
            prev_q      <= '0;
            upd_q       <= '0;
            wcnt_q      <= '0;
`ifdef KALMAN_SCHED_COAST_EN
            coast_q     <= '0;
            is_coast_q  <= 1'b0;
`endif
        end else begin
            st_q        <= st_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            upd_trk_q   <= upd_trk_d;
            tbl_q       <= tbl_d;
            miss_q      <= miss_d;
            act_q       <= act_d;
            wr_q        <= wr_d;
            ack_q       <= ack_d;
            tick_pend_q <= tick_pend_d;
            start_q     <= start_d;
            init_q      <= init_d;
            upd_vld_q   <= upd_vld_d;
            zx_q        <= zx_d;
            zy_q        <= zy_d;
            prev_q      <= prev_d;
            upd_q       <= upd_d;
            wcnt_q      <= wcnt_d;
`ifdef KALMAN_SCHED_COAST_EN
            coast_q     <= coast_d;
            is_coast_q  <= is_coast_d;
`endif
        end
    end

    assign o_Meas_Ack     = ack_q;
    assign o_Kf_Start     = start_q;
    assign o_Kf_Init      = init_q;
    assign o_Kf_Z_X       = zx_q;
    assign o_Kf_Z_Y       = zy_q;
    assign o_Kf_Prev_X    = prev_q.x;
    assign o_Kf_Prev_Y    = prev_q.y;
    assign o_Kf_Prev_VX   = prev_q.vx;
    assign o_Kf_Prev_VY   = prev_q.vy;
    assign o_Upd_Valid    = upd_vld_q;
    assign o_Upd_Track    = upd_trk_q;
    assign o_Upd_X        = upd_q.x;
    assign o_Upd_Y        = upd_q.y;
    assign o_Upd_VX       = upd_q.vx;
    assign o_Upd_VY       = upd_q.vy;
    assign o_Track_Active = act_q;

endmodule

// File: tb/tb_kalman_track_sched.sv
// Randomized rounds of requests against a queue-based reference model of the scheduler,
// with an emulated update unit and a monitor that pops expected strobes/updates.
// Covers reset, init vs update, round-robin order, aging/drop, deferred ticks and reset mid-operation.
module tb_kalman_track_sched;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int TMO = 8;

    typedef struct packed {
        logic        init;
        logic [15:0] zx, zy, px, py, pvx, pvy;
    } iss_t;
    typedef struct packed {
        logic [1:0]  trk;
        logic [15:0] x, y, vx, vy;
    } upd_t;

    logic               clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic [N-1:0]       meas_vld = '0;
    logic [N*16-1:0]    meas_x = '0, meas_y = '0;
    logic [N-1:0]       ack, active;
    logic               kf_start, kf_init, upd_vld;
    logic [15:0]        z_x, z_y, p_x, p_y, kf_x, kf_y, u_x, u_y;
    logic signed [15:0] p_vx, p_vy, kf_vx, kf_vy, u_vx, u_vy;
    logic [1:0]         u_trk;

    kalman_track_sched #(.N_TRACKS(N), .CALC_LAT(LAT), .TIMEOUT(TMO)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Frame_Tick(tick),
        .i_Meas_Valid(meas_vld), .i_Meas_X(meas_x), .i_Meas_Y(meas_y),
        .o_Meas_Ack(ack), .o_Kf_Start(kf_start), .o_Kf_Init(kf_init),
        .o_Kf_Z_X(z_x), .o_Kf_Z_Y(z_y), .o_Kf_Prev_X(p_x), .o_Kf_Prev_Y(p_y),
        .o_Kf_Prev_VX(p_vx), .o_Kf_Prev_VY(p_vy),
        .i_Kf_X(kf_x), .i_Kf_Y(kf_y), .i_Kf_VX(kf_vx), .i_Kf_VY(kf_vy),
        .o_Upd_Valid(upd_vld), .o_Upd_Track(u_trk), .o_Upd_X(u_x), .o_Upd_Y(u_y),
        .o_Upd_VX(u_vx), .o_Upd_VY(u_vy), .o_Track_Active(active)
    );

    always #5 clk = ~clk;

    int   tests = 0, fails = 0, cyc = 0, last_strobe = 0;
    bit   mon_en = 1'b0;
    iss_t q_iss[$];
    upd_t q_upd[$];
    iss_t me;
    upd_t mu;

    // Reference model state
    logic [15:0] m_x[N], m_y[N], m_vx[N], m_vy[N];
    bit          m_act[N], m_wrote[N];
    int          m_miss[N], m_ptr;
    logic [15:0] dx[N], dy[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_vx[k] = 0; m_vy[k] = 0;
            m_act[k] = 0; m_wrote[k] = 0; m_miss[k] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic model_age();
        for (int k = 0; k < N; k++) begin
            if (m_act[k] && !m_wrote[k]) begin
                if (m_miss[k] < 15) m_miss[k]++;
                if (m_miss[k] == TMO) m_act[k] = 0;
            end
            m_wrote[k] = 0;
        end
    endtask

    function automatic logic [N-1:0] m_actv();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_act[k];
        return v;
    endfunction

    // Serve the round's requests in round-robin order from the model pointer.
    task automatic model_round(input logic [N-1:0] mask, input int tmode);
        logic [N-1:0] pend;
        bit first;
        pend = mask;
        first = 1;
        while (pend != 0) begin
            int k;
            iss_t e;
            upd_t u;
            k = -1;
            for (int i = 0; i < N; i++)
                if (k < 0 && pend[(m_ptr + i) % N]) k = (m_ptr + i) % N;
            e.init = !m_act[k];
            e.zx = dx[k]; e.zy = dy[k];
            e.px = m_x[k]; e.py = m_y[k]; e.pvx = m_vx[k]; e.pvy = m_vy[k];
            u.trk = 2'(k);
            u.x = dx[k]; u.y = dy[k];
            u.vx = e.init ? 16'd0 : dx[k] - m_x[k];
            u.vy = e.init ? 16'd0 : dy[k] - m_y[k];
            q_iss.push_back(e);
            q_upd.push_back(u);
            m_x[k] = u.x; m_y[k] = u.y; m_vx[k] = u.vx; m_vy[k] = u.vy;
            m_act[k] = 1; m_miss[k] = 0; m_wrote[k] = 1;
            m_ptr = (k + 1) % N;
            pend[k] = 1'b0;
            if (first && tmode != 0) model_age();
            first = 0;
        end
    endtask

    // tmode: 0 no tick, 1 tick during the first ISSUE, 2 tick during the first WRITE.
    task automatic run_round(input logic [N-1:0] mask, input int tmode);
        int  budget, tick_at;
        bit  seen;
        for (int k = 0; k < N; k++) begin
            meas_x[16*k +: 16] = dx[k];
            meas_y[16*k +: 16] = dy[k];
        end
        model_round(mask, tmode);
        meas_vld = mask;
        seen = 0; tick_at = -1; budget = 0;
        while (meas_vld != 0 && budget < 300) begin
            @(negedge clk);
            budget++;
            tick = (tick_at == budget);
            if (!seen && (kf_start || kf_init)) begin
                seen = 1;
                if (tmode == 1) tick = 1'b1;
                else if (tmode == 2) tick_at = budget + LAT;
            end
            meas_vld = meas_vld & ~ack;
        end
        @(negedge clk);
        tick = 1'b0;
        chk("round_all_acked", 64'(meas_vld), 64'd0);
        meas_vld = '0;
        repeat (3) @(negedge clk);
        chk("active_after_round", 64'(active), 64'(m_actv()));
    endtask

    task automatic idle_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        model_age();
        @(negedge clk);
        chk("active_after_tick", 64'(active), 64'(m_actv()));
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) begin
            dx[k] = 16'($urandom);
            dy[k] = 16'($urandom);
        end
    endtask

    task automatic reset_in_wait();
        bit seen;
        logic got;
        mon_en = 1'b0;
        dx[2] = 16'($urandom);
        meas_x[32 +: 16] = dx[2];
        meas_vld = 4'b0100;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = kf_start || kf_init;
        end
        chk("rst_strobe_seen", 64'(seen), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ctrl_outs", 64'({kf_start, kf_init, upd_vld, ack, active}), 64'd0);
        chk("rst_kf_bus", {z_x, z_y, p_x, p_y}, 64'd0);
        chk("rst_kf_vel", 64'({p_vx, p_vy}), 64'd0);
        chk("rst_upd_bus", {u_x, u_y, u_vx, u_vy}, 64'd0);
        meas_vld = '0;
        q_iss.delete();
        q_upd.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got = 1'b0;
        repeat (10) begin
            @(negedge clk);
            got = got | upd_vld | (|ack);
        end
        chk("no_upd_after_rst", 64'(got), 64'd0);
        model_reset();
        mon_en = 1'b1;
    endtask

    // Emulated update unit: result is valid only in the cycle CALC_LAT after the strobe.
    initial begin : unit
        logic [15:0] rx, ry, rvx, rvy;
        kf_x = 0; kf_y = 0; kf_vx = 0; kf_vy = 0;
        forever begin
            @(negedge clk);
            if (!rst && (kf_start || kf_init)) begin
                rx = z_x; ry = z_y;
                rvx = kf_init ? 16'd0 : z_x - p_x;
                rvy = kf_init ? 16'd0 : z_y - p_y;
                repeat (LAT) @(posedge clk);
                #1;
                kf_x = rx; kf_y = ry; kf_vx = rvx; kf_vy = rvy;
                @(posedge clk);
                #1;
                kf_x = 16'($urandom); kf_y = 16'($urandom);
                kf_vx = 16'($urandom); kf_vy = 16'($urandom);
            end
        end
    end

    // Monitor: compare every strobe and every update against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (kf_start || kf_init) begin
                last_strobe = cyc;
                if (q_iss.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_strobe: start=%0b init=%0b, expected none", kf_start, kf_init);
                end else begin
                    me = q_iss.pop_front();
                    chk("strobe_kind", 64'({kf_start, kf_init}), me.init ? 64'd1 : 64'd2);
                    chk("meas_z", 64'({z_x, z_y}), 64'({me.zx, me.zy}));
                    chk("prev_state", {p_x, p_y, p_vx, p_vy}, {me.px, me.py, me.pvx, me.pvy});
                end
            end
            if (upd_vld) begin
                if (q_upd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_upd: track=%0d, expected none", u_trk);
                end else begin
                    mu = q_upd.pop_front();
                    chk("upd_track", 64'(u_trk), 64'(mu.trk));
                    chk("upd_state", {u_x, u_y, u_vx, u_vy}, {mu.x, mu.y, mu.vx, mu.vy});
                    chk("ack_onehot", 64'(ack), 64'(4'b0001 << mu.trk));
                    chk("strobe_to_upd_lat", 64'(cyc - last_strobe), 64'(LAT + 1));
                end
            end else if (ack != 0) begin
                tests++; fails++;
                $display("FAIL ack_without_upd: ack=%0h, expected 0", ack);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin : stim
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", 64'({kf_start, kf_init, upd_vld, ack, active}), 64'd0);
        chk("reset_bus", {z_x, z_y, u_x, u_y}, 64'd0);
        mon_en = 1'b1;

        // First measurement on track 2 initialises it.
        rand_data();
        dx[2] = 16'd100; dy[2] = 16'd50;
        run_round(4'b0100, 0);

        // All four together: round-robin order from pointer 3 (after track 2).
        rand_data();
        run_round(4'b1111, 0);

        // Track 1 moves left by 3 pixels: X=120, VX=-3, then reused as prior state.
        dx[1] = 16'd123; run_round(4'b0010, 0);
        dx[1] = 16'd120; run_round(4'b0010, 0);
        chk("track1_vx", 64'(m_vx[1]), 64'(16'hFFFD));
        dx[1] = 16'd118; run_round(4'b0010, 0);

        for (int r = 0; r < 40; r++) begin
            rand_data();
            run_round(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 3)) idle_tick();
        end

        // Timeout: refresh all, then TMO measurement-free ticks after the first.
        rand_data();
        run_round(4'b1111, 0);
        repeat (TMO + 1) idle_tick();
        chk("all_dropped", 64'(active), 64'd0);
        rand_data();
        run_round(4'b0001, 0);

        reset_in_wait();
        rand_data();
        run_round(4'b1111, 0);

        chk("iss_queue_drained", 64'(q_iss.size()), 64'd0);
        chk("upd_queue_drained", 64'(q_upd.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
